// File: rtl/alu_share_arb_if.sv
// Purpose: request/response bundle between N_REQ requesters and the shared ALU.
// Signals:
//   req_valid[N_REQ]         per-requester request valid      (requester -> ALU)
//   req_op[4*N_REQ]          per-requester opcode             (requester -> ALU)
//   req_a/req_b[WIDTH*N_REQ] per-requester operands           (requester -> ALU)
//   req_ready[N_REQ]         one-hot grant, combinational     (ALU -> requester)
//   resp_valid/id/data/err   response payload                 (ALU -> consumer)
//   resp_ready               consumer acceptance              (consumer -> ALU)
//   busy                     high whenever the ALU is not idle
interface alu_share_arb_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_REQ = 3
);
   localparam int unsigned IDW = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [4*N_REQ-1:0]     req_op;
   logic [WIDTH*N_REQ-1:0] req_a;
   logic [WIDTH*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]       req_ready;
   logic                   resp_valid;
   logic [IDW-1:0]         resp_id;
   logic [WIDTH-1:0]       resp_data;
   logic                   resp_err;
   logic                   resp_ready;
   logic                   busy;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_data, resp_err, busy
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_id, resp_data, resp_err, busy
   );
endinterface

// File: rtl/alu_share_arb.sv
// Purpose: one ALU shared round-robin by N_REQ requesters. Single-cycle ops
//          answer the cycle after acceptance; DIV/MOD use a WIDTH-step
//          restoring divider. Responses hold until resp_ready.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   bus_io  alu_share_arb_if.slave (request lanes, grant, response, busy)
module alu_share_arb #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_REQ = 3
) (
   input  logic           clk,
   input  logic           rst,
   alu_share_arb_if.slave bus_io
);
   localparam int unsigned IDW = $clog2(N_REQ);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = $clog2(WIDTH + 1);
   localparam logic [3:0]  OP_DIV = 4'd11;
   localparam logic [3:0]  OP_MOD = 4'd12;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_RESP} state_t;

   state_t           state_q;
   logic [IDW-1:0]   ptr_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             resp_valid_q, resp_err_q, busy_q;
   logic [IDW-1:0]   resp_id_q;
   logic [WIDTH-1:0] resp_data_q;

   // Round-robin search: first valid requester at or after ptr_q, wrapping.
   logic             gnt_vld_c;
   logic [IDW-1:0]   gnt_id_c;
   logic [N_REQ-1:0] gnt_c;
   int unsigned      idx_c;
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_id_c  = '0;
      gnt_c     = '0;
      idx_c     = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx_c = 32'(ptr_q) + k;
         if (idx_c >= N_REQ) idx_c = idx_c - N_REQ;
         if (!gnt_vld_c && bus_io.req_valid[idx_c]) begin
            gnt_vld_c = 1'b1;
            gnt_id_c  = IDW'(idx_c);
         end
      end
      if (gnt_vld_c) gnt_c[gnt_id_c] = 1'b1;
   end

   logic accept_c;
   assign accept_c         = (state_q == S_IDLE) && gnt_vld_c;
   assign bus_io.req_ready = (state_q == S_IDLE && !rst) ? gnt_c : '0;

   // Granted lane
   logic [3:0]       g_op_c;
   logic [WIDTH-1:0] g_a_c, g_b_c;
   assign g_op_c = bus_io.req_op[4*gnt_id_c +: 4];
   assign g_a_c  = bus_io.req_a[WIDTH*gnt_id_c +: WIDTH];
   assign g_b_c  = bus_io.req_b[WIDTH*gnt_id_c +: WIDTH];

   // Single-cycle results; DIV/MOD entries only matter for a zero divisor.
   logic [WIDTH-1:0] alu_res_c;
   logic             alu_err_c;
   logic [SHW-1:0]   sh_c;
   assign sh_c = g_b_c[SHW-1:0];
   always_comb begin
      alu_res_c = '0;
      alu_err_c = 1'b0;
      case (g_op_c)
         4'd0:    alu_res_c = g_a_c + g_b_c;
         4'd1:    alu_res_c = g_a_c - g_b_c;
         4'd2:    alu_res_c = g_a_c & g_b_c;
         4'd3:    alu_res_c = g_a_c | g_b_c;
         4'd4:    alu_res_c = g_a_c ^ g_b_c;
         4'd5:    alu_res_c = g_a_c << sh_c;
         4'd6:    alu_res_c = g_a_c >> sh_c;
         4'd7:    alu_res_c = $unsigned($signed(g_a_c) >>> sh_c);
         4'd8:    alu_res_c = WIDTH'(g_a_c == g_b_c);
         4'd9:    alu_res_c = WIDTH'(g_a_c > g_b_c);
         4'd10:   alu_res_c = WIDTH'(g_a_c * g_b_c);
         4'd11:   alu_res_c = '1;
         4'd12:   alu_res_c = g_a_c;
         default: alu_err_c = 1'b1;
      endcase
   end

   // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
   logic [WIDTH:0]   rem_sh_c, rem_sub_c;
   logic             q_bit_c;
   logic [WIDTH-1:0] rem_nxt_c, quo_nxt_c;
   assign rem_sh_c  = {rem_q, quo_q[WIDTH-1]};
   assign rem_sub_c = rem_sh_c - {1'b0, dvs_q};
   assign q_bit_c   = ~rem_sub_c[WIDTH];
   assign rem_nxt_c = q_bit_c ? rem_sub_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
   assign quo_nxt_c = {quo_q[WIDTH-2:0], q_bit_c};

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         op_q         <= '0;
         quo_q        <= '0;
         rem_q        <= '0;
         dvs_q        <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_c) begin
                  op_q      <= g_op_c;
                  resp_id_q <= gnt_id_c;
                  ptr_q     <= (gnt_id_c == IDW'(N_REQ - 1)) ? '0 : IDW'(gnt_id_c + 1'b1);
                  quo_q     <= g_a_c;
                  dvs_q     <= g_b_c;
                  rem_q     <= '0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  if ((g_op_c == OP_DIV || g_op_c == OP_MOD) && g_b_c != '0) begin
                     state_q <= S_DIV;
                  end else begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_data_q  <= alu_res_c;
                     resp_err_q   <= alu_err_c;
                  end
               end
            end
            S_DIV: begin
               quo_q <= quo_nxt_c;
               rem_q <= rem_nxt_c;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= (op_q == OP_DIV) ? quo_nxt_c : rem_nxt_c;
                  resp_err_q   <= 1'b0;
               end
            end
            S_RESP: begin
               if (bus_io.resp_ready) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus_io.resp_valid = resp_valid_q;
   assign bus_io.resp_id    = resp_id_q;
   assign bus_io.resp_data  = resp_data_q;
   assign bus_io.resp_err   = resp_err_q;
   assign bus_io.busy       = busy_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Purpose: directed self-checking bench for alu_share_arb (WIDTH=8, N_REQ=3).
module tb_alu_share_arb;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned N_REQ = 3;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_share_arb_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

   alu_share_arb #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.req_valid[i]      = 1'b1;
      bus.req_op[4*i +: 4]  = op;
      bus.req_a[8*i +: 8]   = a;
      bus.req_b[8*i +: 8]   = b;
   endtask

   task automatic clr_req(input int i);
      bus.req_valid[i] = 1'b0;
   endtask

   // Requester 2 issues op; waits (bounded) for the response and checks latency/data.
   task automatic run_div(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
      int n;
      set_req(2, op, a, b);
      settle();
      chk({tag, "_grant"}, 32'(bus.req_ready), 32'h4);
      tick();
      clr_req(2);
      chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
      n = 1;
      while (bus.resp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_data"}, 32'(bus.resp_data), 32'(exp));
      chk({tag, "_err"}, 32'(bus.resp_err), 32'h0);
      chk({tag, "_id"}, 32'(bus.resp_id), 32'h2);
      tick();
      chk({tag, "_idle"}, 32'(bus.resp_valid), 32'h0);
   endtask

   initial begin
      int id;
      logic seen;
      rst            = 1'b1;
      bus.req_valid  = '0;
      bus.req_op     = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b1;

      // Reset state
      #1;
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_valid", 32'(bus.resp_valid), 32'h0);
      chk("rst_data", 32'(bus.resp_data), 32'h0);
      chk("rst_id", 32'(bus.resp_id), 32'h0);
      chk("rst_err", 32'(bus.resp_err), 32'h0);
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Round robin with all three requesters holding ADD
      for (int i = 0; i < 3; i++) set_req(i, 4'd0, 8'(i + 1), 8'h10);
      settle();
      for (int k = 0; k < 4; k++) begin
         id = k % 3;
         chk("rr_grant", 32'(bus.req_ready), 32'(1 << id));
         chk("rr_idle_busy", 32'(bus.busy), 32'h0);
         chk("rr_idle_valid", 32'(bus.resp_valid), 32'h0);
         tick();
         chk("rr_valid", 32'(bus.resp_valid), 32'h1);
         chk("rr_id", 32'(bus.resp_id), 32'(id));
         chk("rr_data", 32'(bus.resp_data), 32'(8'h11 + id));
         chk("rr_resp_ready0", 32'(bus.req_ready), 32'h0);
         chk("rr_busy", 32'(bus.busy), 32'h1);
         if (k == 3) bus.req_valid = '0;
         tick();
      end
      chk("rr_end_valid", 32'(bus.resp_valid), 32'h0);

      // Requester 1 ADD with carry-out truncation
      set_req(1, 4'd0, 8'hF0, 8'h20);
      settle();
      chk("add_grant", 32'(bus.req_ready), 32'h2);
      tick();
      chk("add_valid", 32'(bus.resp_valid), 32'h1);
      chk("add_id", 32'(bus.resp_id), 32'h1);
      chk("add_data", 32'(bus.resp_data), 32'h10);
      chk("add_err", 32'(bus.resp_err), 32'h0);
      clr_req(1);
      tick();
      chk("add_idle", 32'(bus.busy), 32'h0);

      // Divider and divide-by-zero
      run_div("div", 4'd11, 8'd200, 8'd7, 8'd28, 9);
      run_div("mod", 4'd12, 8'd200, 8'd7, 8'd4, 9);
      run_div("div0", 4'd11, 8'd200, 8'd0, 8'hFF, 1);
      run_div("mod0", 4'd12, 8'd200, 8'd0, 8'd200, 1);

      // SRA and illegal opcode on requester 0
      set_req(0, 4'd7, 8'h84, 8'h0A);
      settle();
      chk("sra_grant", 32'(bus.req_ready), 32'h1);
      tick();
      chk("sra_data", 32'(bus.resp_data), 32'hE1);
      chk("sra_err", 32'(bus.resp_err), 32'h0);
      clr_req(0);
      tick();
      set_req(0, 4'd14, 8'h55, 8'h33);
      settle();
      tick();
      chk("ill_valid", 32'(bus.resp_valid), 32'h1);
      chk("ill_err", 32'(bus.resp_err), 32'h1);
      chk("ill_data", 32'(bus.resp_data), 32'h0);
      clr_req(0);
      tick();

      // Back-pressure: response held while resp_ready is low
      bus.resp_ready = 1'b0;
      set_req(0, 4'd0, 8'd3, 8'd4);
      set_req(1, 4'd0, 8'd5, 8'd6);
      settle();
      chk("bp_grant", 32'(bus.req_ready), 32'h2);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", 32'(bus.resp_valid), 32'h1);
         chk("bp_id", 32'(bus.resp_id), 32'h1);
         chk("bp_data", 32'(bus.resp_data), 32'h0B);
         chk("bp_err", 32'(bus.resp_err), 32'h0);
         chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
         chk("bp_busy", 32'(bus.busy), 32'h1);
      end
      bus.resp_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(bus.resp_valid), 32'h0);
      chk("bp_next_grant", 32'(bus.req_ready), 32'h1);
      tick();
      chk("bp_next_id", 32'(bus.resp_id), 32'h0);
      chk("bp_next_data", 32'(bus.resp_data), 32'h07);
      bus.req_valid = '0;
      tick();

      // Reset during a divide
      set_req(1, 4'd11, 8'd100, 8'd3);
      set_req(2, 4'd11, 8'd50, 8'd5);
      settle();
      chk("rd_grant", 32'(bus.req_ready), 32'h2);
      tick();
      tick();
      tick();
      tick();
      rst = 1'b1;
      settle();
      chk("rd_busy", 32'(bus.busy), 32'h0);
      chk("rd_valid", 32'(bus.resp_valid), 32'h0);
      chk("rd_ready", 32'(bus.req_ready), 32'h0);
      tick();
      tick();
      chk("rd_hold_valid", 32'(bus.resp_valid), 32'h0);
      rst = 1'b0;
      settle();
      chk("rd_regrant", 32'(bus.req_ready), 32'h2);
      bus.req_valid = '0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.resp_valid !== 1'b0) seen = 1'b1;
      end
      chk("rd_no_resp", 32'(seen), 32'h0);
      chk("rd_end_busy", 32'(bus.busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
